ipml_sfifo_fwft_v2_0: RTL

IPML_SFIFO_FWFT_V2_0 -- requirements
Module: ipml_sfifo_fwft_v2_0

---
 rtl/ipml_sfifo_fwft_v2_0_pkg.sv | 42 ++++
 rtl/ipml_sfifo_ram_v2_0.sv | 39 +++
 rtl/ipml_sfifo_fwft_v2_0.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ipml_sfifo_fwft_v2_0_pkg.sv
// ---------------------------------------------------------------------------
// ipml_sfifo_fwft_v2_0_pkg
// Shared constants and helpers for the synchronous FIFO:
//   FWFT_OFF / FWFT_ON : read-mode selector values for c_FWFT
//   params_ok()        : parameter legality check, evaluated at elaboration
//   ptr_full()         : full test on wrap-bit pointers of width pw
// ---------------------------------------------------------------------------
package ipml_sfifo_fwft_v2_0_pkg;

    localparam int FWFT_OFF  = 0;
    localparam int FWFT_ON   = 1;

    // Widest pointer the FIFO can need (depth width 16 plus the wrap bit).
    localparam int PTR_W_MAX = 17;

    function automatic bit params_ok(input int depth_w, input int data_w,
                                     input int fwft, input int af_num,
                                     input int ae_num);
        bit ok;
        int depth;
        ok = 1'b1;
        if (depth_w < 4 || depth_w > 16) ok = 1'b0;
        if (data_w < 1 || data_w > 256) ok = 1'b0;
        if (fwft != FWFT_OFF && fwft != FWFT_ON) ok = 1'b0;
        // Depth is only meaningful once depth_w is known to be in range.
        if (ok) begin
            depth = 1 << depth_w;
            if (af_num < 1 || af_num > depth - 1) ok = 1'b0;
            if (ae_num < 1 || ae_num > depth - 1) ok = 1'b0;
        end
        return ok;
    endfunction

    // Pointers carry one extra wrap bit: full when only the wrap bit differs.
    // Callers zero-extend to PTR_W_MAX, so bits above pw-1 always match.
    function automatic logic ptr_full(input logic [PTR_W_MAX-1:0] wp,
                                      input logic [PTR_W_MAX-1:0] rp,
                                      input int pw);
        return (wp ^ rp) == (PTR_W_MAX'(1) << (pw - 1));
    endfunction

endpackage

// File: rtl/ipml_sfifo_ram_v2_0.sv
// ---------------------------------------------------------------------------
// ipml_sfifo_ram_v2_0
// Simple dual-port RAM, one clock, synchronous registered read.
//   clk      : clock
//   rst      : synchronous active-high reset of the read-data register only
//   wr_en    : write strobe, wr_addr / wr_data
//   rd_en    : read strobe, rd_addr; rd_data updates on the next edge and
//              holds while rd_en is low
// Array contents are never reset so the storage maps onto block RAM.
// ---------------------------------------------------------------------------
module ipml_sfifo_ram_v2_0 #(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [c_ADDR_WIDTH-1:0] wr_addr,
    input  logic [c_DATA_WIDTH-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [c_ADDR_WIDTH-1:0] rd_addr,
    output logic [c_DATA_WIDTH-1:0] rd_data
);

    logic [c_DATA_WIDTH-1:0] mem_q [0:(1 << c_ADDR_WIDTH)-1];
    logic [c_DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ipml_sfifo_fwft_v2_0.sv
// ---------------------------------------------------------------------------
// ipml_sfifo_fwft_v2_0
// Single-clock FIFO, depth 2^c_DEPTH_WIDTH, standard or first-word-fall-
// through read mode.
//   clk, rst          : clock, synchronous active-high reset
//   wr_data, wr_en    : write port; wr_full, almost_full, overflow status
//   rd_en             : read request (standard) / pop (FWFT)
//   rd_data           : read data; rd_empty, almost_empty, underflow status
//   water_level       : words held, including an FWFT prefetched head word
// All status outputs are registered.
// ---------------------------------------------------------------------------
module ipml_sfifo_fwft_v2_0
    import ipml_sfifo_fwft_v2_0_pkg::*;
#(
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_DATA_WIDTH       = 16,
    parameter int c_FWFT             = 0,
    parameter int c_ALMOST_FULL_NUM  = 1020,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int              PW      = c_DEPTH_WIDTH + 1;
    localparam bit              IS_FWFT = (c_FWFT == FWFT_ON);
    localparam logic [PW-1:0]   ONE     = PW'(1);
    localparam logic [PW-1:0]   AF_LVL  = PW'(c_ALMOST_FULL_NUM);
    localparam logic [PW-1:0]   AE_LVL  = PW'(c_ALMOST_EMPTY_NUM);

    if (!params_ok(c_DEPTH_WIDTH, c_DATA_WIDTH, c_FWFT,
                   c_ALMOST_FULL_NUM, c_ALMOST_EMPTY_NUM)) begin : g_bad_param
        $error("ipml_sfifo_fwft_v2_0: illegal parameter combination");
    end

    // wr_ptr : next RAM slot to write
    // rd_ptr : next RAM slot to fetch into the output register
    // hd_ptr : slot of the head word the user sees; equals rd_ptr in
    //          standard mode, lags it by the prefetched word in FWFT mode.
    //          Full is judged against hd_ptr so the prefetched word keeps
    //          its slot until popped.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] hd_ptr_q, hd_ptr_d;
    logic [PW-1:0] level_q,  level_d;
    logic          out_vld_q, out_vld_d;
    logic          wr_full_q, wr_full_d;
    logic          almost_full_q, almost_full_d;
    logic          rd_empty_q, rd_empty_d;
    logic          almost_empty_q, almost_empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wr_acc, rd_acc, ram_rd, ram_we;

    always_comb begin
        wr_acc = wr_en & ~wr_full_q;
        rd_acc = rd_en & ~rd_empty_q;

        // FWFT: fetch whenever RAM holds an unfetched word and the output
        // register is free now or being popped this cycle (no bubble).
        if (IS_FWFT) ram_rd = (rd_ptr_q != wr_ptr_q) && (!out_vld_q || rd_acc);
        else         ram_rd = rd_acc;

        ram_we   = wr_acc & ~rst;

        wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = ram_rd ? rd_ptr_q + ONE : rd_ptr_q;
        hd_ptr_d = rd_acc ? hd_ptr_q + ONE : hd_ptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase

        if (ram_rd)      out_vld_d = 1'b1;
        else if (rd_acc) out_vld_d = 1'b0;
        else             out_vld_d = out_vld_q;

        wr_full_d      = ptr_full(PTR_W_MAX'(wr_ptr_d), PTR_W_MAX'(hd_ptr_d), PW);
        almost_full_d  = (level_d >= AF_LVL);
        almost_empty_d = (level_d <= AE_LVL);
        // FWFT empties on the output register, standard mode on the count.
        rd_empty_d     = IS_FWFT ? ~out_vld_d : (level_d == '0);
        overflow_d     = wr_en & wr_full_q;
        underflow_d    = rd_en & rd_empty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            hd_ptr_q       <= '0;
            level_q        <= '0;
            out_vld_q      <= 1'b0;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            rd_empty_q     <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            hd_ptr_q       <= hd_ptr_d;
            level_q        <= level_d;
            out_vld_q      <= out_vld_d;
            wr_full_q      <= wr_full_d;
            almost_full_q  <= almost_full_d;
            rd_empty_q     <= rd_empty_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    ipml_sfifo_ram_v2_0 #(
        .c_ADDR_WIDTH (c_DEPTH_WIDTH),
        .c_DATA_WIDTH (c_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[c_DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q[c_DEPTH_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    assign wr_full      = wr_full_q;
    assign almost_full  = almost_full_q;
    assign rd_empty     = rd_empty_q;
    assign almost_empty = almost_empty_q;
    assign water_level  = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
